// File: rtl/kernel_convolve.sv
// Sequential Gaussian-filter MAC: latches a kernel and a pixel window on start,
// accumulates one tap per cycle over a k x k region, then rounds and saturates to 8 bits.
module kernel_convolve #(
  parameter int MAX_KERNEL = 7
) (
  input  logic                                         clk,
  input  logic                                         n_rst,
  input  logic                                         start,
  input  logic [$clog2(MAX_KERNEL)-1:0]                kernel_size,
  input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]   kernel,
  input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]   window,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         err,
  output logic [7:0]                                   pixel_out
);

  localparam int KW    = $clog2(MAX_KERNEL);
  localparam int ACC_W = 16 + $clog2(MAX_KERNEL * MAX_KERNEL);
  localparam logic [KW-1:0] CTR = KW'((MAX_KERNEL - 1) / 2);

  typedef enum logic [1:0] {IDLE, MAC, ROUND, DONE} state_t;
  typedef logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] mat_t;

  state_t           state;
  logic [KW-1:0]    k_q, ti, tj;
  mat_t             ker_q, win_q;
  logic [ACC_W-1:0] acc;
  logic [7:0]       res;
  logic             bad_q;

  logic [KW-1:0]    kr, row, col;
  logic [15:0]      prod;
  logic             bad_k;
  logic [ACC_W:0]   rnd;
  logic [7:0]       sat;

  always_comb begin
    kr    = (k_q - KW'(1)) >> 1;
    row   = CTR - kr + ti;
    col   = CTR - kr + tj;
    prod  = ker_q[ti][tj] * win_q[row][col];
    bad_k = (kernel_size == '0) || !kernel_size[0] || (32'(kernel_size) > MAX_KERNEL);
    rnd   = {1'b0, acc} + (ACC_W + 1)'(128);
    // Anything at or above bit 16 after rounding means the shifted result exceeds 255.
    sat   = (|rnd[ACC_W:16]) ? 8'hFF : rnd[15:8];
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      k_q       <= '0;
      ti        <= '0;
      tj        <= '0;
      ker_q     <= '0;
      win_q     <= '0;
      acc       <= '0;
      res       <= '0;
      bad_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pixel_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            k_q   <= kernel_size;
            ker_q <= kernel;
            win_q <= window;
            acc   <= '0;
            ti    <= '0;
            tj    <= '0;
            bad_q <= bad_k;
            state <= bad_k ? DONE : MAC;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          if (tj == k_q - KW'(1)) begin
            tj <= '0;
            if (ti == k_q - KW'(1)) state <= ROUND;
            else                    ti    <= ti + KW'(1);
          end else begin
            tj <= tj + KW'(1);
          end
        end
        ROUND: begin
          res   <= sat;
          state <= DONE;
        end
        DONE: begin
          done      <= 1'b1;
          err       <= bad_q;
          pixel_out <= bad_q ? 8'd0 : res;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_convolve.sv
// Self-checking bench for kernel_convolve: directed cases plus random jobs
// compared against a plain-arithmetic convolution model.
module tb_kernel_convolve;
  localparam int MK = 7;
  localparam int C  = (MK - 1) / 2;
  typedef logic [MK-1:0][MK-1:0][7:0] mat_t;

  logic       clk = 1'b0;
  logic       n_rst, start;
  logic [2:0] kernel_size;
  mat_t       kernel, window;
  logic       busy, done, err;
  logic [7:0] pixel_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kernel_convolve #(.MAX_KERNEL(MK)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .kernel_size(kernel_size),
    .kernel(kernel), .window(window), .busy(busy), .done(done),
    .err(err), .pixel_out(pixel_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic mat_t rnd_mat();
    mat_t m;
    for (int i = 0; i < MK; i++)
      for (int j = 0; j < MK; j++) m[i][j] = 8'($urandom);
    return m;
  endfunction

  function automatic mat_t fill(input int v);
    mat_t m;
    for (int i = 0; i < MK; i++)
      for (int j = 0; j < MK; j++) m[i][j] = 8'(v);
    return m;
  endfunction

  // Weighted sum over the k x k neighbourhood centred on the window centre.
  function automatic int model(input int k, input mat_t kr, input mat_t w);
    int r, sum, q;
    r = (k - 1) / 2;
    sum = 0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        sum += int'(kr[i][j]) * int'(w[C - r + i][C - r + j]);
    q = (sum + 128) / 256;
    return (q > 255) ? 255 : q;
  endfunction

  // Issues one job; reports latency, outputs, busy-before-done cycles,
  // busy one cycle after done, and total done pulses seen.
  task automatic run(input int k, input mat_t kern, input mat_t win, input bit scramble,
                     output int lat, output int pix, output int e, output int bcnt,
                     output int bafter, output int dcnt);
    bit seen;
    @(negedge clk);
    kernel_size = 3'(k); kernel = kern; window = win; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; bcnt = 0; dcnt = 0; seen = 0;
    while (lat < 200 && !seen) begin
      if (busy && !done) bcnt++;
      if (scramble) begin
        start  = (lat < 20) ? 1'($urandom) : 1'b0;
        kernel = rnd_mat();
        window = rnd_mat();
      end
      @(negedge clk);
      lat++;
      if (done) begin seen = 1; dcnt++; end
    end
    if (!seen) check("timeout", 32'(lat), 32'(0));
    start = 1'b0;
    pix = int'(pixel_out);
    e = int'(err);
    @(negedge clk);
    bafter = int'(busy);
    if (done) dcnt++;
    repeat (4) begin
      @(negedge clk);
      if (done) dcnt++;
    end
  endtask

  initial begin
    int lat, pix, e, bcnt, bafter, dcnt, k, exp_pix, dcnt_r;
    mat_t kk, ww;

    n_rst = 1'b0; start = 1'b0; kernel_size = '0; kernel = '0; window = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_pix", 32'(pixel_out), 0);
    n_rst = 1'b1;

    // Identity, k=1
    kk = rnd_mat(); kk[0][0] = 8'd255;
    ww = rnd_mat(); ww[C][C] = 8'd200;
    run(1, kk, ww, 0, lat, pix, e, bcnt, bafter, dcnt);
    check("id_lat", 32'(lat), 3);
    check("id_pix", 32'(pix), 199);
    check("id_err", 32'(e), 0);
    check("id_ndone", 32'(dcnt), 1);

    // Box 3x3
    run(3, fill(28), fill(100), 0, lat, pix, e, bcnt, bafter, dcnt);
    check("box_lat", 32'(lat), 11);
    check("box_pix", 32'(pix), 98);
    check("box_busy", 32'(bcnt), 11);
    check("box_busy_after", 32'(bafter), 0);

    // Saturation 7x7
    run(7, fill(255), fill(255), 0, lat, pix, e, bcnt, bafter, dcnt);
    check("sat_lat", 32'(lat), 51);
    check("sat_pix", 32'(pix), 255);

    // Off-centre mapping
    kk = fill(0); kk[0][0] = 8'd255;
    ww = fill(0); ww[C-1][C-1] = 8'd255;
    run(3, kk, ww, 0, lat, pix, e, bcnt, bafter, dcnt);
    check("off_pix", 32'(pix), 254);

    // Illegal sizes
    run(4, fill(10), fill(10), 0, lat, pix, e, bcnt, bafter, dcnt);
    check("k4_lat", 32'(lat), 1);
    check("k4_err", 32'(e), 1);
    check("k4_pix", 32'(pix), 0);
    check("k4_ndone", 32'(dcnt), 1);
    run(0, fill(10), fill(10), 0, lat, pix, e, bcnt, bafter, dcnt);
    check("k0_lat", 32'(lat), 1);
    check("k0_err", 32'(e), 1);
    check("k0_pix", 32'(pix), 0);
    run(3, fill(28), fill(100), 0, lat, pix, e, bcnt, bafter, dcnt);
    check("clr_err", 32'(e), 0);
    check("clr_pix", 32'(pix), 98);

    // Random legal jobs
    for (int n = 0; n < 6; n++) begin
      k = 2 * $urandom_range(0, 3) + 1;
      kk = rnd_mat(); ww = rnd_mat();
      exp_pix = model(k, kk, ww);
      run(k, kk, ww, 0, lat, pix, e, bcnt, bafter, dcnt);
      check($sformatf("rnd%0d_k%0d_pix", n, k), 32'(pix), 32'(exp_pix));
      check($sformatf("rnd%0d_k%0d_lat", n, k), 32'(lat), 32'(k * k + 2));
      check($sformatf("rnd%0d_err", n), 32'(e), 0);
    end

    // Inputs and start churn during a k=5 run
    kk = rnd_mat(); ww = rnd_mat();
    exp_pix = model(5, kk, ww);
    run(5, kk, ww, 1, lat, pix, e, bcnt, bafter, dcnt);
    check("scr_pix", 32'(pix), 32'(exp_pix));
    check("scr_lat", 32'(lat), 27);
    check("scr_ndone", 32'(dcnt), 1);

    // Reset mid-MAC
    @(negedge clk);
    kernel_size = 3'd5; kernel = rnd_mat(); window = rnd_mat(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    n_rst = 1'b0;
    @(negedge clk);
    check("mr_busy", 32'(busy), 0);
    check("mr_done", 32'(done), 0);
    check("mr_err", 32'(err), 0);
    check("mr_pix", 32'(pixel_out), 0);
    n_rst = 1'b1;
    dcnt_r = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dcnt_r++;
    end
    check("mr_nodone", 32'(dcnt_r), 0);
    kk = rnd_mat(); ww = rnd_mat();
    exp_pix = model(5, kk, ww);
    run(5, kk, ww, 0, lat, pix, e, bcnt, bafter, dcnt);
    check("post_pix", 32'(pix), 32'(exp_pix));
    check("post_lat", 32'(lat), 27);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/kernel_convolve.md
# kernel_convolve

Sequential Gaussian-filter MAC engine: the consumer of the kernel produced by CreateKernel. On `start` it latches a kernel array and a pixel window centred on the output pixel. It then multiply-accumulates one tap per cycle over a `kernel_size` × `kernel_size` region and returns one rounded, saturated 8-bit blurred pixel with a one-cycle `done` pulse. It sits between the kernel generator and the FAST corner-detection window logic in the ISP pipeline.

## Interface
- `MAX_KERNEL`, 7: largest supported (odd) kernel dimension; sizes the kernel and window arrays.
- `clk`  in  1: rising-edge clock.
- `n_rst`  in  1: reset, synchronous, active-low.
- `start`  in  1: request one convolution; sampled only in IDLE.
- `kernel_size`  in  $clog2(MAX_KERNEL): active kernel dimension k; legal values are odd, 1..MAX_KERNEL.
- `kernel`  in  [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]: Q0.8 weights, top-left aligned; tap (i,j) = `kernel[i][j]`, i,j < k.
- `window`  in  [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]: pixel neighbourhood; centre at index C = (MAX_KERNEL-1)/2.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the result or error is valid.
- `err`  out  1: the last accepted start had an illegal `kernel_size`.
- `pixel_out`  out  8: convolved pixel.

## Operation
- States: IDLE, MAC, ROUND, DONE.
- **IDLE**
  - On `start`=1: register `kernel`, `kernel_size` and `window` into internal copies. Upstream may change these inputs afterwards.
  - Clear the accumulator and the tap counters (i, j).
  - If k is 0, even, or > MAX_KERNEL, go to DONE with the error flag set. Otherwise go to MAC.
- **MAC**
  - With r = (k-1)/2, each cycle do: acc += kernel[i][j] × window[C-r+i][C-r+j].
  - j increments; on j = k-1, j wraps to 0 and i increments.
  - After tap (k-1, k-1), go to ROUND. MAC therefore lasts exactly k² cycles.
- **ROUND**
  - Compute res = (acc + 128) >> 8; saturate res to 255.
  - Go to DONE.
- **DONE**
  - Register `pixel_out` (0 on the error path) and `err`; assert `done`.
  - Return to IDLE.
- Arithmetic:
  - 8×8 unsigned products.
  - Accumulator is 22 bits unsigned (16 + ceil(log2 49)) and never wraps.
  - Rounding adds before shifting.
- `pixel_out` and `err` hold until the next DONE. `err` is cleared by the next successful DONE.
- `start` in MAC, ROUND or DONE is ignored. It is neither queued nor an error.
- `n_rst`=0 at any clock edge, including mid-MAC, has these effects:
  - State goes to IDLE.
  - Accumulator and counters are cleared.
  - `busy`, `done`, `err` go to 0 and `pixel_out` goes to 0. No `done` is produced for the aborted job.
- Reset values: `busy`=0, `done`=0, `err`=0, `pixel_out`=0.

## Timing
- `start` sampled high at edge t (IDLE), legal k:
  - `busy`=1 from after edge t until the end of the `done` cycle.
  - MAC occupies edges t+1 .. t+k².
  - ROUND occupies edge t+k²+1.
  - `done`, `pixel_out` and `err` are registered at edge t+k²+2.
  - Latency: k²+2 cycles. k=3 gives 11; k=7 gives 51.
- Illegal k: `done`=1 with `err`=1 and `pixel_out`=0 registered at edge t+1. Latency 1.
- `busy` drops on the edge where `done` falls. A new `start` is accepted on the first edge after `done`. Back-to-back throughput is k²+3 cycles per pixel.
- All outputs are registered. There are no combinational paths from input to output.

## Test plan
- Identity, k=1, `kernel[0][0]`=255, window centre=200 -> `done` 3 cycles after start, `pixel_out`=199, `err`=0.
- Box, k=3, all nine weights=28, window all 100 -> acc=25200, `pixel_out`=98, `done` at edge t+11, `busy` high for exactly 11 cycles.
- Saturation, k=7, all weights=255, window all 255 -> `pixel_out`=255, `done` at edge t+51. Also covers the off-centre window mapping: k=3 with only `window[C-1][C-1]`=255 and only `kernel[0][0]`=255 -> 254.
- Illegal sizes: k=4, then k=0 -> `done` at edge t+1, `err`=1, `pixel_out`=0. A following legal k=3 run clears `err`.
- Robustness: during a k=5 run, toggle `start`, `kernel` and `window` -> result still matches the latched inputs, only one `done`. Pull `n_rst` low for 1 cycle at MAC cycle 10 -> all outputs 0 on the next edge, no `done`, next `start` runs normally.
